// File: rtl/ysyx_2022040010_div_ctrl_pkg.sv
// Shared constants for the RV64M divide/remainder issue controller:
// result-select codes, FSM state codes, the signed-minimum operands and a
// 32->64 sign-extension helper.
package ysyx_2022040010_div_ctrl_pkg;

   localparam int DATA_W = 64;

   // Divider result select
   localparam logic [1:0] RES_SEL_IDLE = 2'b00;
   localparam logic [1:0] RES_SEL_REM  = 2'b01;
   localparam logic [1:0] RES_SEL_QUO  = 2'b10;

   // Controller FSM states
   localparam logic [1:0] DIV_CTRL_IDLE = 2'd0;
   localparam logic [1:0] DIV_CTRL_WAIT = 2'd1;
   localparam logic [1:0] DIV_CTRL_DONE = 2'd2;

   // Most negative signed values; MIN / -1 is the overflow case
   localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
   localparam logic [31:0] MIN32 = 32'h8000_0000;

   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

endpackage

// File: rtl/ysyx_2022040010_div_ctrl_opprep.sv
// Combinational operand preparation for the divide controller.
// Extends *W operands (sign- or zero-extension by signedness), derives the
// divider result select, and flags divide-by-zero / signed overflow together
// with the architecturally fixed result for those cases.
module ysyx_2022040010_div_opprep
   import ysyx_2022040010_div_ctrl_pkg::*;
(
   input  logic [2:0]        op,
   input  logic              word,
   input  logic [DATA_W-1:0] rs1,
   input  logic [DATA_W-1:0] rs2,
   output logic              is_signed,
   output logic [1:0]        res_sel,
   output logic [DATA_W-1:0] op1,
   output logic [DATA_W-1:0] op2,
   output logic              special,
   output logic [DATA_W-1:0] special_res
);

   logic signed [31:0] a32;
   logic signed [31:0] b32;
   logic               is_rem;
   logic               div_zero;
   logic               overflow;
   // funct3[2] is always set for this op group; only the low bits select behaviour
   logic               unused_funct3_msb;

   assign unused_funct3_msb = op[2];

   // Extend a 32-bit operand to 64 bits according to signedness
   function automatic logic [DATA_W-1:0] extend_word(input logic signed [31:0] v,
                                                     input logic sgn);
      return sgn ? sext32(v) : {32'b0, v};
   endfunction

   // Fixed RISC-V result for divide-by-zero and signed overflow
   function automatic logic [DATA_W-1:0] special_result(input logic dz,
                                                        input logic ov,
                                                        input logic rem,
                                                        input logic wd,
                                                        input logic [DATA_W-1:0] dividend);
      if (dz)
         return rem ? (wd ? sext32(dividend[31:0]) : dividend) : '1;
      else if (ov)
         return rem ? '0 : (wd ? sext32(MIN32) : MIN64);
      else
         return '0;
   endfunction

   // Decode, extend operands and detect special cases
   always_comb begin
      a32         = $signed(rs1[31:0]);
      b32         = $signed(rs2[31:0]);
      is_signed   = ~op[0];
      is_rem      = op[1];
      res_sel     = is_rem ? RES_SEL_REM : RES_SEL_QUO;
      op1         = word ? extend_word(a32, is_signed) : rs1;
      op2         = word ? extend_word(b32, is_signed) : rs2;
      div_zero    = word ? (b32 == 32'sd0) : (rs2 == '0);
      overflow    = is_signed &
                    (word ? ((rs1[31:0] == MIN32) && (b32 == -32'sd1))
                          : ((rs1 == MIN64) && (rs2 == '1)));
      special     = div_zero | overflow;
      special_res = special_result(div_zero, overflow, is_rem, word, rs1);
   end

endmodule

// File: rtl/ysyx_2022040010_div_ctrl.sv
// EX-stage issue/control unit in front of ysyx_2022040010_div.
// Accepts DIV/DIVU/REM/REMU(+W), registers prepared operands, drives the
// divider start/annul handshake, stalls the pipe while the divider works,
// overrides divide-by-zero and MIN/-1 results, and aborts via a watchdog.
// Optional build macro: DIV_FASTPATH_EN -- special cases finish without the
// divider, one cycle after accept.
module ysyx_2022040010_div_ctrl
   import ysyx_2022040010_div_ctrl_pkg::*;
#(
   parameter int DIV_TIMEOUT = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_div_valid_i,
   input  logic [2:0]        ex_div_op_i,
   input  logic              ex_div_word_i,
   input  logic [DATA_W-1:0] ex_rs1_i,
   input  logic [DATA_W-1:0] ex_rs2_i,
   input  logic [4:0]        ex_rd_i,
   input  logic              flush_i,
   output logic              stall_req_o,
   output logic              div_done_o,
   output logic [DATA_W-1:0] div_wdata_o,
   output logic [4:0]        div_rd_o,
   output logic              div_err_o,
   output logic              div_start_o,
   output logic              div_annul_o,
   output logic              div_signed_o,
   output logic              div_32_o,
   output logic [DATA_W-1:0] div_op1_o,
   output logic [DATA_W-1:0] div_op2_o,
   output logic [1:0]        div_res_sel_o,
   input  logic [DATA_W-1:0] div_res_i,
   input  logic              div_ready_i
);

   localparam int CNT_W = $clog2(DIV_TIMEOUT);

   logic [1:0]        state_q;
   logic              accept;

   logic              prep_signed;
   logic [1:0]        prep_sel;
   logic [DATA_W-1:0] prep_op1;
   logic [DATA_W-1:0] prep_op2;
   logic              prep_special;
   logic [DATA_W-1:0] prep_special_res;

   logic [DATA_W-1:0] op1_p1;
   logic [DATA_W-1:0] op2_p1;
   logic [4:0]        rd_p1;
   logic              signed_p1;
   logic              word_p1;
   logic [1:0]        sel_p1;
   logic              spec_p1;
   logic [DATA_W-1:0] spec_res_p1;
   logic              vld_p1;
   logic [CNT_W-1:0]  cnt_p1;

   logic [DATA_W-1:0] wdata_p2;
   logic              vld_p2;
   logic              err_p2;
   logic              annul_p2;

   ysyx_2022040010_div_opprep u_opprep (
      .op          (ex_div_op_i),
      .word        (ex_div_word_i),
      .rs1         (ex_rs1_i),
      .rs2         (ex_rs2_i),
      .is_signed   (prep_signed),
      .res_sel     (prep_sel),
      .op1         (prep_op1),
      .op2         (prep_op2),
      .special     (prep_special),
      .special_res (prep_special_res)
   );

   assign accept = (state_q == DIV_CTRL_IDLE) & ex_div_valid_i & ~flush_i;

   // Hold IF/ID/EX while an op is being accepted or the divider is busy
   assign stall_req_o = accept | (state_q == DIV_CTRL_WAIT);

   // FSM, operand stage (_p1) and result stage (_p2) registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= DIV_CTRL_IDLE;
         op1_p1      <= '0;
         op2_p1      <= '0;
         rd_p1       <= '0;
         signed_p1   <= 1'b0;
         word_p1     <= 1'b0;
         sel_p1      <= RES_SEL_IDLE;
         spec_p1     <= 1'b0;
         spec_res_p1 <= '0;
         vld_p1      <= 1'b0;
         cnt_p1      <= '0;
         wdata_p2    <= '0;
         vld_p2      <= 1'b0;
         err_p2      <= 1'b0;
         annul_p2    <= 1'b0;
      end else begin
         vld_p2   <= 1'b0;
         err_p2   <= 1'b0;
         annul_p2 <= 1'b0;
         case (state_q)
            // ---- IDLE -> operand stage: latch the prepared op ----
            DIV_CTRL_IDLE: begin
               if (accept) begin
                  op1_p1      <= prep_op1;
                  op2_p1      <= prep_op2;
                  rd_p1       <= ex_rd_i;
                  signed_p1   <= prep_signed;
                  word_p1     <= ex_div_word_i;
                  spec_p1     <= prep_special;
                  spec_res_p1 <= prep_special_res;
                  cnt_p1      <= '0;
`ifdef DIV_FASTPATH_EN
                  if (prep_special) begin
                     state_q  <= DIV_CTRL_DONE;
                     wdata_p2 <= prep_special_res;
                     vld_p2   <= 1'b1;
                  end else begin
                     state_q <= DIV_CTRL_WAIT;
                     vld_p1  <= 1'b1;
                     sel_p1  <= prep_sel;
                  end
`else
                  state_q <= DIV_CTRL_WAIT;
                  vld_p1  <= 1'b1;
                  sel_p1  <= prep_sel;
`endif
               end
            end
            // ---- WAIT -> result stage: capture, abort or annul ----
            DIV_CTRL_WAIT: begin
               if (flush_i) begin
                  state_q  <= DIV_CTRL_IDLE;
                  annul_p2 <= 1'b1;
                  vld_p1   <= 1'b0;
                  sel_p1   <= RES_SEL_IDLE;
                  cnt_p1   <= '0;
               end else if (div_ready_i) begin
                  state_q  <= DIV_CTRL_DONE;
                  wdata_p2 <= spec_p1 ? spec_res_p1 : div_res_i;
                  vld_p2   <= 1'b1;
                  vld_p1   <= 1'b0;
                  sel_p1   <= RES_SEL_IDLE;
                  cnt_p1   <= '0;
               end else if (cnt_p1 == CNT_W'(DIV_TIMEOUT - 1)) begin
                  state_q  <= DIV_CTRL_DONE;
                  wdata_p2 <= '0;
                  vld_p2   <= 1'b1;
                  err_p2   <= 1'b1;
                  vld_p1   <= 1'b0;
                  sel_p1   <= RES_SEL_IDLE;
                  cnt_p1   <= '0;
               end else begin
                  cnt_p1 <= cnt_p1 + CNT_W'(1);
               end
            end
            // ---- DONE: result pulse already visible, return to IDLE ----
            DIV_CTRL_DONE: begin
               state_q <= DIV_CTRL_IDLE;
               cnt_p1  <= '0;
               if (flush_i)
                  annul_p2 <= 1'b1;
            end
            default: begin
               state_q <= DIV_CTRL_IDLE;
               vld_p1  <= 1'b0;
               sel_p1  <= RES_SEL_IDLE;
               cnt_p1  <= '0;
            end
         endcase
      end
   end

   assign div_done_o    = vld_p2;
   assign div_err_o     = err_p2;
   assign div_wdata_o   = wdata_p2;
   assign div_rd_o      = rd_p1;
   assign div_start_o   = vld_p1;
   assign div_annul_o   = annul_p2;
   assign div_signed_o  = signed_p1;
   assign div_32_o      = word_p1;
   assign div_op1_o     = op1_p1;
   assign div_op2_o     = op2_p1;
   assign div_res_sel_o = sel_p1;

endmodule

// File: tb/tb_ysyx_2022040010_div_ctrl.sv
// Bench for ysyx_2022040010_div_ctrl. The bench plays the divider: it answers
// with the architectural result (or a corrupted value for the special cases,
// which the controller must override) after a chosen latency, and compares
// everything against a plain-arithmetic RISC-V reference model.
module tb_ysyx_2022040010_div_ctrl;

   localparam int TIMEOUT = 128;

   logic        clk;
   logic        rst;
   logic        ex_div_valid_i;
   logic [2:0]  ex_div_op_i;
   logic        ex_div_word_i;
   logic [63:0] ex_rs1_i;
   logic [63:0] ex_rs2_i;
   logic [4:0]  ex_rd_i;
   logic        flush_i;
   logic        stall_req_o;
   logic        div_done_o;
   logic [63:0] div_wdata_o;
   logic [4:0]  div_rd_o;
   logic        div_err_o;
   logic        div_start_o;
   logic        div_annul_o;
   logic        div_signed_o;
   logic        div_32_o;
   logic [63:0] div_op1_o;
   logic [63:0] div_op2_o;
   logic [1:0]  div_res_sel_o;
   logic [63:0] div_res_i;
   logic        div_ready_i;

   int n_checks;
   int n_fails;

   ysyx_2022040010_div_ctrl #(.DIV_TIMEOUT(TIMEOUT)) dut (
      .clk            (clk),
      .rst            (rst),
      .ex_div_valid_i (ex_div_valid_i),
      .ex_div_op_i    (ex_div_op_i),
      .ex_div_word_i  (ex_div_word_i),
      .ex_rs1_i       (ex_rs1_i),
      .ex_rs2_i       (ex_rs2_i),
      .ex_rd_i        (ex_rd_i),
      .flush_i        (flush_i),
      .stall_req_o    (stall_req_o),
      .div_done_o     (div_done_o),
      .div_wdata_o    (div_wdata_o),
      .div_rd_o       (div_rd_o),
      .div_err_o      (div_err_o),
      .div_start_o    (div_start_o),
      .div_annul_o    (div_annul_o),
      .div_signed_o   (div_signed_o),
      .div_32_o       (div_32_o),
      .div_op1_o      (div_op1_o),
      .div_op2_o      (div_op2_o),
      .div_res_sel_o  (div_res_sel_o),
      .div_res_i      (div_res_i),
      .div_ready_i    (div_ready_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, act, exp);
      end
   endtask

   // RISC-V M-extension semantics, straight from the ISA rules
   function automatic logic [63:0] ref_result(input logic [2:0] op, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
      logic        sgn, rem;
      logic [31:0] x, y, q32, r32;
      logic [63:0] q64, r64;
      sgn = ~op[0];
      rem = op[1];
      if (w) begin
         x = a[31:0];
         y = b[31:0];
         if (y == 32'd0) begin
            q32 = 32'hFFFF_FFFF; r32 = x;
         end else if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q32 = x; r32 = 32'd0;
         end else if (sgn) begin
            q32 = $signed(x) / $signed(y); r32 = $signed(x) % $signed(y);
         end else begin
            q32 = x / y; r32 = x % y;
         end
         return rem ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
      end else begin
         if (b == 64'd0) begin
            q64 = '1; r64 = a;
         end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q64 = a; r64 = 64'd0;
         end else if (sgn) begin
            q64 = $signed(a) / $signed(b); r64 = $signed(a) % $signed(b);
         end else begin
            q64 = a / b; r64 = a % b;
         end
         return rem ? r64 : q64;
      end
   endfunction

   function automatic logic is_special(input logic [2:0] op, input logic w,
                                       input logic [63:0] a, input logic [63:0] b);
      if (w)
         return (b[31:0] == 32'd0) ||
                (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
      return (b == 64'd0) || (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1);
   endfunction

   function automatic logic [63:0] exp_operand(input logic [2:0] op, input logic w,
                                               input logic [63:0] v);
      if (!w) return v;
      return op[0] ? {32'd0, v[31:0]} : {{32{v[31]}}, v[31:0]};
   endfunction

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_done"},  div_done_o, 0);
      check_eq({tag, "_err"},   div_err_o, 0);
      check_eq({tag, "_start"}, div_start_o, 0);
      check_eq({tag, "_annul"}, div_annul_o, 0);
      check_eq({tag, "_sel"},   div_res_sel_o, 0);
      check_eq({tag, "_stall"}, stall_req_o, 0);
      check_eq({tag, "_wdata"}, div_wdata_o, 0);
      check_eq({tag, "_rd"},    div_rd_o, 0);
      check_eq({tag, "_op1"},   div_op1_o, 0);
      check_eq({tag, "_op2"},   div_op2_o, 0);
      check_eq({tag, "_sgn"},   div_signed_o, 0);
      check_eq({tag, "_w32"},   div_32_o, 0);
   endtask

   // Issue one op; lat = WAIT cycle index where ready is raised (-1: never),
   // flush_cyc = WAIT cycle index where flush is raised (-1: never)
   task automatic run_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd,
                         input int lat, input int flush_cyc);
      logic [63:0] exp_res;
      logic        spec, fast, got_done;
      int          exp_idx, idx;
      exp_res = ref_result(op, w, a, b);
      spec    = is_special(op, w, a, b);
      fast    = 1'b0;
`ifdef DIV_FASTPATH_EN
      fast    = spec;
`endif
      exp_idx = fast ? 0 : ((lat >= 0) ? lat + 1 : TIMEOUT);

      @(negedge clk);
      ex_div_valid_i = 1'b1;
      ex_div_op_i    = op;
      ex_div_word_i  = w;
      ex_rs1_i       = a;
      ex_rs2_i       = b;
      ex_rd_i        = rd;
      #1;
      check_eq("stall_accept", stall_req_o, 1);
      @(negedge clk);
      ex_div_valid_i = 1'b0;
      ex_rs1_i       = {$urandom, $urandom};
      ex_rs2_i       = {$urandom, $urandom};

      got_done = 1'b0;
      idx      = -1;
      for (int i = 0; i < TIMEOUT + 10; i++) begin
         if (div_done_o) begin
            got_done = 1'b1;
            idx      = i;
            break;
         end
         check_eq("start_wait", div_start_o, 1);
         check_eq("stall_wait", stall_req_o, 1);
         if (i == 0) begin
            check_eq("op1", div_op1_o, exp_operand(op, w, a));
            check_eq("op2", div_op2_o, exp_operand(op, w, b));
            check_eq("signed", div_signed_o, !op[0]);
            check_eq("w32", div_32_o, w);
            check_eq("res_sel", div_res_sel_o, op[1] ? 2'b01 : 2'b10);
         end
         if (i == flush_cyc) begin
            flush_i = 1'b1;
            @(negedge clk);
            flush_i = 1'b0;
            check_eq("flush_annul", div_annul_o, 1);
            check_eq("flush_no_done", div_done_o, 0);
            check_eq("flush_no_err", div_err_o, 0);
            check_eq("flush_start", div_start_o, 0);
            check_eq("flush_stall", stall_req_o, 0);
            @(negedge clk);
            check_eq("annul_pulse", div_annul_o, 0);
            check_eq("flush_no_done2", div_done_o, 0);
            return;
         end
         if (i == lat) begin
            div_ready_i = 1'b1;
            div_res_i   = spec ? ~exp_res : exp_res;
         end
         @(negedge clk);
         div_ready_i = 1'b0;
         div_res_i   = {$urandom, $urandom};
      end
      check_eq("done_seen", got_done, 1);
      check_eq("done_latency", idx, exp_idx);
      check_eq("wdata", div_wdata_o, (lat < 0 && !fast) ? 64'd0 : exp_res);
      check_eq("err", div_err_o, (lat < 0 && !fast));
      check_eq("rd", div_rd_o, rd);
      check_eq("done_start", div_start_o, 0);
      check_eq("done_sel", div_res_sel_o, 0);
      check_eq("done_stall", stall_req_o, 0);
      @(negedge clk);
      check_eq("done_pulse", div_done_o, 0);
      check_eq("err_pulse", div_err_o, 0);
      check_eq("wdata_held", div_wdata_o, (lat < 0 && !fast) ? 64'd0 : exp_res);
   endtask

   initial begin
      logic [2:0]  op;
      logic        w;
      logic [63:0] a, b;
      int          lat, fl;
      n_checks       = 0;
      n_fails        = 0;
      rst            = 1'b1;
      ex_div_valid_i = 1'b0;
      ex_div_op_i    = 3'b100;
      ex_div_word_i  = 1'b0;
      ex_rs1_i       = '0;
      ex_rs2_i       = '0;
      ex_rd_i        = '0;
      flush_i        = 1'b0;
      div_res_i      = '0;
      div_ready_i    = 1'b0;

      repeat (2) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;

      // DIVU 100/7 -> 14, rd 5, ready on the third WAIT cycle
      run_op(3'b101, 1'b0, 64'd100, 64'd7, 5'd5, 2, -1);
      // REMW / DIVW on MIN32 and -1
      run_op(3'b110, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 1, -1);
      run_op(3'b100, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 1, -1);
      // divide by zero
      run_op(3'b100, 1'b0, 64'd1234, 64'd0, 5'd8, 2, -1);
      run_op(3'b110, 1'b0, -64'sd9, 64'd0, 5'd9, 0, -1);
      // flush in the 2nd WAIT cycle, then a normal op
      run_op(3'b100, 1'b0, 64'd50, 64'd5, 5'd10, 4, 1);
      run_op(3'b111, 1'b0, 64'd50, 64'd7, 5'd11, 1, -1);

      // flush together with valid in IDLE: not accepted
      @(negedge clk);
      ex_div_valid_i = 1'b1;
      flush_i        = 1'b1;
      ex_rs1_i       = 64'd9;
      ex_rs2_i       = 64'd3;
      #1;
      check_eq("flush_valid_stall", stall_req_o, 0);
      @(negedge clk);
      ex_div_valid_i = 1'b0;
      flush_i        = 1'b0;
      check_eq("flush_valid_start", div_start_o, 0);
      check_eq("flush_valid_done", div_done_o, 0);

      // watchdog: ready never comes
      run_op(3'b101, 1'b0, 64'd77, 64'd3, 5'd12, -1, -1);

      // async reset mid-WAIT
      @(negedge clk);
      ex_div_valid_i = 1'b1;
      ex_div_op_i    = 3'b100;
      ex_div_word_i  = 1'b0;
      ex_rs1_i       = 64'd40;
      ex_rs2_i       = 64'd6;
      ex_rd_i        = 5'd13;
      @(negedge clk);
      ex_div_valid_i = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_idle_outputs("async_rst");
      @(negedge clk);
      rst = 1'b0;
      run_op(3'b100, 1'b0, 64'd20, -64'sd3, 5'd14, 2, -1);

      // randomized ops, biased toward the special cases
      for (int n = 0; n < 40; n++) begin
         op = {1'b1, 2'($urandom_range(0, 3))};
         w  = 1'($urandom_range(0, 1));
         a  = {$urandom, $urandom};
         b  = {$urandom, $urandom};
         case ($urandom_range(0, 5))
            0: b = w ? {$urandom, 32'd0} : 64'd0;
            1: begin
               a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
               b = w ? {$urandom, 32'hFFFF_FFFF} : '1;
            end
            2: begin
               a = 64'($urandom_range(0, 1000));
               b = 64'($urandom_range(1, 20));
            end
            3: b = -64'($urandom_range(1, 20));
            default: ;
         endcase
         lat = $urandom_range(0, 5);
         fl  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, lat) : -1;
         run_op(op, w, a, b, 5'($urandom_range(0, 31)), lat, fl);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
